vg_pattern_gen: RTL

VG_PATTERN_GEN -- requirements
Module: vg_pattern_gen

---
 rtl/vg_pattern_gen_if.sv | 30 +++
 rtl/vg_pattern_gen.sv | 138 +++++++++++++
 2 files changed

// File: rtl/vg_pattern_gen_if.sv
// Video pattern generator bus: timing strobes and coordinates in, colour and
// delayed strobes out. The slave modport is the generator's view.
interface vg_pattern_gen_if #(
    parameter int X_BITS = 12,
    parameter int Y_BITS = 12
);
    logic              hs_in;
    logic              vs_in;
    logic              hde_in;
    logic              vde_in;
    logic [X_BITS-1:0] x_in;
    logic [Y_BITS:0]   y_in;
    logic [2:0]        pattern_sel;
    logic [7:0]        r_out;
    logic [7:0]        g_out;
    logic [7:0]        b_out;
    logic              hs_out;
    logic              vs_out;
    logic              de_out;
    logic [7:0]        frame_cnt;

    modport master (
        output hs_in, vs_in, hde_in, vde_in, x_in, y_in, pattern_sel,
        input  r_out, g_out, b_out, hs_out, vs_out, de_out, frame_cnt
    );
    modport slave (
        input  hs_in, vs_in, hde_in, vde_in, x_in, y_in, pattern_sel,
        output r_out, g_out, b_out, hs_out, vs_out, de_out, frame_cnt
    );
endinterface

// File: rtl/vg_pattern_gen.sv
// Two-stage test pattern generator (bars, checker, ramps, grid, solids).
// Define VG_PATTERN_ANIM_EN to scroll patterns 2 px per frame.
module vg_pattern_gen #(
    parameter int X_BITS = 12,
    parameter int Y_BITS = 12
) (
    input  logic           clk,
    input  logic           reset_n,
    vg_pattern_gen_if.slave vif
);
    // Stage 1: registered strobes and only the coordinate bits the patterns use
    logic       hs1_q, vs1_q, de1_q;
    logic [9:0] x1_q;
    logic [7:0] y1_q;     // y_in[8:1], field bit dropped
    logic [2:0] pat_q, pat_d;
    logic [7:0] fcnt_q, fcnt_d;
    logic       vs_rise;

    // Stage 2: output registers
    logic [7:0] r_q, g_q, b_q;
    logic [7:0] r_d, g_d, b_d;
    logic       hs2_q, vs2_q, de2_q;
    logic [7:0] fcnt2_q;

    logic [9:0] ofs, xe;
    logic [2:0] bar;

    // vs1_q doubles as the edge-detect history; it clears on reset so the
    // first high sample afterwards counts as a rising edge.
    assign vs_rise = vif.vs_in & ~vs1_q;

    always_comb begin
        pat_d  = pat_q;
        fcnt_d = fcnt_q;
        if (vs_rise) begin
            pat_d  = vif.pattern_sel;
            fcnt_d = fcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs1_q  <= 1'b0;
            vs1_q  <= 1'b0;
            de1_q  <= 1'b0;
            x1_q   <= '0;
            y1_q   <= '0;
            pat_q  <= '0;
            fcnt_q <= '0;
        end else begin
            hs1_q  <= vif.hs_in;
            vs1_q  <= vif.vs_in;
            de1_q  <= vif.hde_in & vif.vde_in;
            x1_q   <= 10'(X_BITS'(vif.x_in));
            y1_q   <= 8'((Y_BITS+1)'(vif.y_in) >> 1);
            pat_q  <= pat_d;
            fcnt_q <= fcnt_d;
        end
    end

`ifdef VG_PATTERN_ANIM_EN
    assign ofs = {1'b0, fcnt_q, 1'b0};
`else
    assign ofs = '0;
`endif
    // Only xe[9:0] feeds any pattern, so the wrap of the full column is implied
    assign xe = x1_q + ofs;

    always_comb begin
        r_d = 8'h00;
        g_d = 8'h00;
        b_d = 8'h00;
        bar = ~xe[9:7];   // 7 - idx
        case (pat_q)
            3'd0: begin
                r_d = {8{bar[2]}};
                g_d = {8{bar[1]}};
                b_d = {8{bar[0]}};
            end
            3'd1: begin
                r_d = {8{xe[4] ^ y1_q[4]}};
                g_d = r_d;
                b_d = r_d;
            end
            3'd2: begin
                r_d = xe[7:0];
                g_d = xe[7:0];
                b_d = xe[7:0];
            end
            3'd3: begin
                r_d = y1_q;
                g_d = y1_q;
                b_d = y1_q;
            end
            3'd4: begin
                r_d = {8{(xe[3:0] == 4'd0) || (y1_q[3:0] == 4'd0)}};
                g_d = r_d;
                b_d = r_d;
            end
            3'd5: r_d = 8'hFF;
            3'd6: g_d = 8'hFF;
            default: b_d = 8'hFF;
        endcase
        if (!de1_q) begin
            r_d = 8'h00;
            g_d = 8'h00;
            b_d = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            hs2_q   <= 1'b0;
            vs2_q   <= 1'b0;
            de2_q   <= 1'b0;
            fcnt2_q <= '0;
        end else begin
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            hs2_q   <= hs1_q;
            vs2_q   <= vs1_q;
            de2_q   <= de1_q;
            fcnt2_q <= fcnt_q;
        end
    end

    assign vif.r_out     = r_q;
    assign vif.g_out     = g_q;
    assign vif.b_out     = b_q;
    assign vif.hs_out    = hs2_q;
    assign vif.vs_out    = vs2_q;
    assign vif.de_out    = de2_q;
    assign vif.frame_cnt = fcnt2_q;
endmodule
